// File: rtl/imm_signext_if.sv
// Instruction-to-immediate bus between fetch/decode and the sign-extension unit.
// No ready: imm_valid only qualifies imm_ext, and the consumer must accept the result on every cycle.
interface imm_signext_if;
  logic [31:0] instr;
  logic [63:0] imm_ext;
  logic        imm_valid;

  modport master (
    output instr,
    input  imm_ext,
    input  imm_valid
  );

  modport slave (
    input  instr,
    output imm_ext,
    output imm_valid
  );
endinterface

// File: rtl/imm_signext.sv
// LEGv8 immediate decode: picks the immediate field by opcode, then sign- or zero-extends it to 64 bits.
// The result is registered with one cycle of latency. Unknown opcodes produce zero with imm_valid low.
module imm_signext (
  input  logic          clk,
  input  logic          rst_n,
  imm_signext_if.slave  bus
);

  logic [63:0] imm_d;
  logic        valid_d;

  // The formats are mutually exclusive, so the priority order only fixes the structure of the logic.
  always_comb begin
    imm_d   = 64'h0;
    valid_d = 1'b0;
    if (bus.instr[31:26] == 6'b000101 || bus.instr[31:26] == 6'b100101) begin
      imm_d   = {{38{bus.instr[25]}}, bus.instr[25:0]};
      valid_d = 1'b1;
    end else if (bus.instr[31:24] == 8'b10110100 || bus.instr[31:24] == 8'b10110101 ||
                 bus.instr[31:24] == 8'b01010100) begin
      imm_d   = {{45{bus.instr[23]}}, bus.instr[23:5]};
      valid_d = 1'b1;
    end else if (bus.instr[31:21] == 11'b11111000010 || bus.instr[31:21] == 11'b11111000000) begin
      imm_d   = {{55{bus.instr[20]}}, bus.instr[20:12]};
      valid_d = 1'b1;
    end else if (bus.instr[31:22] == 10'b1001000100 || bus.instr[31:22] == 10'b1101000100) begin
      // ADDI/SUBI immediates are unsigned.
      imm_d   = {52'h0, bus.instr[21:10]};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imm_ext   <= 64'h0;
      bus.imm_valid <= 1'b0;
    end else begin
      bus.imm_ext   <= imm_d;
      bus.imm_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_imm_signext.sv
// Directed bench for imm_signext: a table of vectors plus sequences for reset and latency.
module tb_imm_signext;

  logic clk;
  logic rst_n;
  imm_signext_if bus ();

  imm_signext dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int vec_count  = 0;
  int fail_count = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] exp_imm;
    logic        exp_valid;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  logic [31:0] ldur_pos, ldur_neg, cbz_neg;

  task automatic check(input string name, input logic [63:0] exp_imm, input logic exp_valid);
    vec_count++;
    if (bus.imm_ext !== exp_imm || bus.imm_valid !== exp_valid) begin
      fail_count++;
      $display("FAIL %s: got imm_ext=%h imm_valid=%b, expected imm_ext=%h imm_valid=%b",
               name, bus.imm_ext, bus.imm_valid, exp_imm, exp_valid);
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge so the value is stable at the next rising edge.
  task automatic drive(input logic [31:0] w);
    @(negedge clk);
    bus.instr = w;
  endtask

  task automatic drive_and_sample(input logic [31:0] w);
    drive(w);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{{8'b10110100, 19'd23, 5'd1},          64'h0000_0000_0000_0017, 1'b1}; // CBZ +23
    vecs[1]  = '{{8'b10110100, 19'h7FFE9, 5'd1},       64'hFFFF_FFFF_FFFF_FFE9, 1'b1}; // CBZ -23
    vecs[2]  = '{{8'b10110101, 19'h7FFFF, 5'd3},       64'hFFFF_FFFF_FFFF_FFFF, 1'b1}; // CBNZ all ones
    vecs[3]  = '{{8'b01010100, 19'h00000, 5'h1F},      64'h0000_0000_0000_0000, 1'b1}; // B.cond zero
    vecs[4]  = '{{11'b11111000010, 9'd23, 12'd1},      64'h0000_0000_0000_0017, 1'b1}; // LDUR +23
    vecs[5]  = '{{11'b11111000010, 9'h1E9, 12'd1},     64'hFFFF_FFFF_FFFF_FFE9, 1'b1}; // LDUR -23
    vecs[6]  = '{{11'b11111000000, 9'd23, 12'd1},      64'h0000_0000_0000_0017, 1'b1}; // STUR +23
    vecs[7]  = '{{11'b11111000000, 9'h1E9, 12'd1},     64'hFFFF_FFFF_FFFF_FFE9, 1'b1}; // STUR -23
    vecs[8]  = '{{11'b11111000010, 9'h100, 12'hFFF},   64'hFFFF_FFFF_FFFF_FF00, 1'b1}; // imm9 min
    vecs[9]  = '{{11'b11111000000, 9'h0FF, 12'h000},   64'h0000_0000_0000_00FF, 1'b1}; // imm9 max
    vecs[10] = '{{11'b10011000000, 9'd23, 12'd1},      64'h0000_0000_0000_0000, 1'b0}; // unknown
    vecs[11] = '{{6'b000101, 26'h3FFFFFF},             64'hFFFF_FFFF_FFFF_FFFF, 1'b1}; // B all ones
    vecs[12] = '{{6'b000101, 26'h2000000},             64'hFFFF_FFFF_FE00_0000, 1'b1}; // B min
    vecs[13] = '{{6'b100101, 26'h1FFFFFF},             64'h0000_0000_01FF_FFFF, 1'b1}; // BL max
    vecs[14] = '{{10'b1001000100, 12'hFFF, 5'h1F, 5'h1F}, 64'h0000_0000_0000_0FFF, 1'b1}; // ADDI
    vecs[15] = '{{10'b1101000100, 12'h800, 5'h00, 5'h00}, 64'h0000_0000_0000_0800, 1'b1}; // SUBI
    vecs[16] = '{32'hFFFF_FFFF,                        64'h0000_0000_0000_0000, 1'b0}; // all-ones word
    ldur_pos = {11'b11111000010, 9'd23, 12'd1};
    ldur_neg = {11'b11111000010, 9'h1E9, 12'd1};
    cbz_neg  = {8'b10110100, 19'h7FFE9, 5'd1};

    // Reset state, including clock edges while reset is held.
    rst_n     = 1'b0;
    bus.instr = vecs[0].instr;
    #1;
    check("reset_initial", 64'h0, 1'b0);
    @(posedge clk); #1;
    check("reset_held_edge", 64'h0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_after_release", vecs[0].exp_imm, vecs[0].exp_valid);

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      drive_and_sample(vecs[i].instr);
      check($sformatf("vec[%0d]", i), vecs[i].exp_imm, vecs[i].exp_valid);
    end

    // Asynchronous reset mid-cycle, then release: the old word must not be replayed.
    drive_and_sample(cbz_neg);
    check("pre_reset_cbz", 64'hFFFF_FFFF_FFFF_FFE9, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 64'h0, 1'b0);
    @(posedge clk); #1;
    check("reset_hold", 64'h0, 1'b0);
    @(negedge clk);
    bus.instr = ldur_pos;
    rst_n     = 1'b1;
    #1;
    check("release_no_update", 64'h0, 1'b0);
    @(posedge clk); #1;
    check("post_release_ldur", 64'h17, 1'b1);

    // Latency: toggle instr each cycle and confirm the output trails by exactly one edge.
    for (int i = 0; i < 8; i++) begin
      drive((i % 2 == 0) ? ldur_neg : ldur_pos);
      #1;
      check($sformatf("lat_before[%0d]", i),
            (i % 2 == 0) ? 64'h17 : 64'hFFFF_FFFF_FFFF_FFE9, 1'b1);
      @(posedge clk); #1;
      check($sformatf("lat_after[%0d]", i),
            (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFE9 : 64'h17, 1'b1);
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/imm_signext.md
Name: imm_signext

Overview:
- Immediate sign-extension unit of the LEGv8 datapath.
- Decodes the opcode of a 32-bit instruction word, extracts the immediate field for that format and extends it to 64 bits.
- Result is registered: one clock of latency into the decode/execute stage that consumes it.
- Unrecognised opcodes produce zero with a cleared valid flag.

Parameters:
- None. Widths are fixed: instruction 32, result 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr  input  32  instruction word to decode
- imm_ext  output  64  registered extended immediate
- imm_valid  output  1  registered; 1 when the sampled opcode matched a known immediate format

Behaviour:
- Reset: rst_n low asynchronously forces imm_ext = 64'h0 and imm_valid = 0, regardless of clk. Outputs hold while rst_n is low.
- Reset release: the first update occurs on the first rising clk edge with rst_n high.
- Latency: exactly one cycle. On every rising clk edge (rst_n high), imm_ext/imm_valid load the value decoded combinationally from the current instr.
- No enable and no stall: the outputs update every cycle.
- Decode uses fixed bit-field compares. The formats below are mutually exclusive; evaluate them in the listed order.
  - B / BL: instr[31:26] = 000101 or 100101. imm26 = instr[25:0], sign-extended using bit 25.
  - CBZ / CBNZ / B.cond: instr[31:24] = 10110100, 10110101 or 01010100. imm19 = instr[23:5], sign-extended using bit 23.
  - LDUR / STUR: instr[31:21] = 11111000010 or 11111000000. imm9 = instr[20:12], sign-extended using bit 20.
  - ADDI / SUBI: instr[31:22] = 1001000100 or 1101000100. imm12 = instr[21:10], zero-extended.
  - Any other opcode: imm_ext = 0, imm_valid = 0.
  - Every recognised format sets imm_valid = 1.
- No scaling: branch offsets are not shifted left by 2. The shift happens downstream.
- Bits of instr outside the opcode and immediate fields (register fields, op2 bits) never affect the result.
- Sign extension is pure bit replication of the field MSB into bits 63..field width. There is no saturation.
- Boundary values:
  - imm9 = 0x100 gives 0xFFFF_FFFF_FFFF_FF00.
  - imm9 = 0x0FF gives 0xFF.
  - imm19 all ones gives -1 (all 64 bits set).
  - imm26 = 0x2000000 gives 0xFFFF_FFFF_FE00_0000.
- Reset asserted between clock edges: outputs clear immediately. The previous instr is discarded, not replayed.
- X on instr: no requirement beyond the registered outputs being deterministic once instr is known.

Test Plan:
- CBZ, instr = {8'b10110100, 19'd23, 5'd1}; one clk later -> imm_ext = 0x0000_0000_0000_0017, imm_valid = 1. Same with imm19 = 19'h7FFE9 (-23) -> imm_ext = 0xFFFF_FFFF_FFFF_FFE9.
- LDUR, instr = {11'b11111000010, 9'd23, 12'd1} -> 0x17, valid = 1. imm9 = 9'h1E9 -> 0xFFFF_FFFF_FFFF_FFE9. STUR (11'b11111000000) gives identical results for the same two immediates.
- Unknown opcode, instr = {11'b10011000000, 9'd23, 12'd1} -> imm_ext = 0, imm_valid = 0.
- B with imm26 = 26'h3FFFFFF -> all ones. ADDI with imm12 = 12'hFFF -> 0x0000_0000_0000_0FFF (zero-extended).
- Reset: drive a CBZ -23 word, clock once (outputs = 0xFF..E9), then pull rst_n low mid-cycle -> both outputs are 0 before the next edge and stay 0 while low.
- Latency: toggle instr every cycle between the LDUR +23 and LDUR -23 words; imm_ext must trail instr by exactly one clock edge.
